ps2_host_transmitter: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the design to the keyboard. It sits next to `ps2_data_input` on the same two open-drain lines. It generates request-to-send, shifts the frame on device-generated clock edges, and checks the device acknowledge. While `tx_busy` is high, the receiver ignores the lines.

---
 rtl/ps2_host_transmitter_pkg.sv | 39 +++
 rtl/ps2_sync_edge.sv | 35 +++
 rtl/ps2_host_transmitter.sv | 217 +++++++++++++++++++++
 tb/tb_ps2_host_transmitter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_transmitter_pkg.sv
// Shared PS/2 definitions: FSM state encodings, frame geometry, common
// keyboard command bytes and the host-to-device frame payload layout.
package ps2_host_transmitter_pkg;

    // Transmitter FSM encodings
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_RTS       = 3'd2;
    localparam logic [2:0] ST_SEND      = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    // Start + 8 data + parity + stop
    localparam int unsigned PS2_FRAME_BITS = 11;
    // Bits shifted out on device clock edges after the start bit
    localparam int unsigned PS2_SHIFT_BITS = 10;

    // Common host commands
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

    // Bits following the start bit, LSB is sent first
    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
    } ps2_tx_frame_t;

    // Build the shifted part of a frame with odd parity
    function automatic ps2_tx_frame_t ps2_build_frame(input logic [7:0] data);
        ps2_tx_frame_t f;
        f.stop   = 1'b1;
        f.parity = ~^data;
        f.data   = data;
        return f;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// 2-FF synchronizer for a raw PS/2 line with a falling-edge strobe.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   line_i     raw asynchronous line level
//   level_o    synchronized level (registered)
//   fall_c     combinational strobe: synchronized 1->0 transition
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic fall_c
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to the idle (pulled-up) level so release never looks like an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign fall_c  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 transmitter: inhibits the clock, issues request-to-send,
// shifts a command byte out on device clock falling edges and checks the
// device acknowledge, with a watchdog from clock release to line idle.
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   tx_data, tx_strb          command byte and single-cycle send request
//   tx_busy                   transfer in progress
//   tx_done, tx_error         one-cycle completion / failure pulses
//   ps2_clk_in, ps2_data_in   raw open-drain line levels
//   ps2_clk_oe, ps2_data_oe   1 pulls the corresponding line low
module ps2_host_transmitter
    import ps2_host_transmitter_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned RTS_CYCLES     = 100,
    parameter int unsigned TIMEOUT_CYCLES = 750_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_strb,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned DLY_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int unsigned DLY_W   = $clog2(DLY_MAX) + 1;
    localparam int unsigned WDOG_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned BIT_W   = $clog2(PS2_FRAME_BITS) + 1;

    // The frequency only documents how the cycle counts map to real time
    logic unused_clk_freq;
    assign unused_clk_freq = ^32'(CLK_FREQ_HZ);

    logic                      clk_level;
    logic                      clk_fall;
    logic                      data_level;
    logic                      data_fall_unused;

    logic [2:0]                state_q,   state_d;
    logic [DLY_W-1:0]          dly_q,     dly_d;
    logic [WDOG_W-1:0]         wdog_q,    wdog_d;
    logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [PS2_SHIFT_BITS-1:0] shift_q,   shift_d;
    logic                      clk_oe_q,  clk_oe_d;
    logic                      data_oe_q, data_oe_d;
    logic                      busy_q,    busy_d;
    logic                      done_q,    done_d;
    logic                      error_q,   error_d;

    logic                      wdog_active;
    logic                      wdog_expired;

    ps2_sync_edge u_sync_clk (
        .clk     (clk),
        .rst     (rst),
        .line_i  (ps2_clk_in),
        .level_o (clk_level),
        .fall_c  (clk_fall)
    );

    ps2_sync_edge u_sync_data (
        .clk     (clk),
        .rst     (rst),
        .line_i  (ps2_data_in),
        .level_o (data_level),
        .fall_c  (data_fall_unused)
    );

    assign wdog_active  = (state_q == ST_SEND) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
    assign wdog_expired = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dly_q     <= '0;
            wdog_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            wdog_q    <= wdog_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        wdog_d    = wdog_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                if (tx_strb) begin
                    shift_d  = ps2_build_frame(tx_data);
                    dly_d    = '0;
                    clk_oe_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                if (dly_q == DLY_W'(INHIBIT_CYCLES - 1)) begin
                    dly_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = ST_RTS;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end

            // Data held low here is the start bit
            ST_RTS: begin
                if (dly_q == DLY_W'(RTS_CYCLES - 1)) begin
                    dly_d     = '0;
                    clk_oe_d  = 1'b0;
                    bit_cnt_d = '0;
                    wdog_d    = '0;
                    state_d   = ST_SEND;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end

            // Each device falling edge presents the next bit; line is open-drain
            ST_SEND: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b1, shift_q[PS2_SHIFT_BITS-1:1]};
                    if (bit_cnt_q == BIT_W'(PS2_SHIFT_BITS - 1)) begin
                        state_d = ST_ACK;
                    end
                end
            end

            ST_ACK: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (clk_fall) begin
                    if (!data_level) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_WAIT_IDLE: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (clk_level && data_level) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        // Watchdog expiry overrides any edge handled above
        if (wdog_active && wdog_expired) begin
            wdog_d    = '0;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            error_d   = 1'b1;
            state_d   = ST_IDLE;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: open-drain line model, a PS/2 device model
// clocking the frame in, and a scoreboard of expected line bits and outcomes.
`timescale 1ns/1ps
module tb_ps2_host_transmitter;
    import ps2_host_transmitter_pkg::*;

    localparam int unsigned INH      = 50;
    localparam int unsigned RTS      = 10;
    localparam int unsigned TMO      = 20000;
    // Short device half period so a whole frame fits inside the watchdog
    localparam int unsigned DEV_HALF = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_strb;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       dev_clk_low;
    logic       dev_data_low;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    logic exp_bits[$];
    int   exp_res[$];   // 0 = tx_done expected, 1 = tx_error expected

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_transmitter #(
        .CLK_FREQ_HZ    (50_000_000),
        .INHIBIT_CYCLES (INH),
        .RTS_CYCLES     (RTS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_strb     (tx_strb),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    // Pulse monitor: busy must already be low when a completion pulse shows
    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            done_cnt++;
            checks++;
            if (tx_busy !== 1'b0 || tx_error !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse: busy=%b error=%b, required 0/0", tx_busy, tx_error);
            end
        end
        if (tx_error === 1'b1) begin
            err_cnt++;
            checks++;
            if (tx_busy !== 1'b0) begin
                errors++;
                $display("FAIL error_pulse: busy=%b, required 0", tx_busy);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_time_limit: bench still running, required to finish");
        $fatal(1, "time limit");
    end

    task automatic send_byte(input logic [7:0] b, input logic par);
        @(negedge clk);
        tx_data = b;
        tx_strb = 1'b1;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
        exp_bits.push_back(par);
        exp_bits.push_back(1'b1);
        @(negedge clk);
        tx_strb = 1'b0;
        checks++;
        if (ps2_clk_oe !== 1'b1 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_latency: clk_oe=%b busy=%b, required 1/1", ps2_clk_oe, tx_busy);
        end
    endtask

    task automatic wait_release(output int inh, output int rts);
        inh = 0;
        rts = 0;
        while (ps2_data_oe !== 1'b1 && inh < 10000) begin
            inh++;
            @(negedge clk);
        end
        while (ps2_clk_oe === 1'b1 && rts < 10000) begin
            rts++;
            @(negedge clk);
        end
    endtask

    // Device: clocks `falls` edges; returns holding clock low if falls < 11
    task automatic device_frame(input logic ack_low, input int falls);
        logic exp_v;
        repeat (DEV_HALF) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) begin
                dev_clk_low = 1'b1;
                repeat (DEV_HALF) @(negedge clk);
                if (i == falls) return;
                dev_clk_low = 1'b0;
            end
            checks++;
            if (exp_bits.size() == 0) begin
                errors++;
                $display("FAIL frame_bit%0d: observed %b, scoreboard empty", i, ps2_data_in);
            end else begin
                exp_v = exp_bits.pop_front();
                if (ps2_data_in !== exp_v) begin
                    errors++;
                    $display("FAIL frame_bit%0d: observed %b, required %b", i, ps2_data_in, exp_v);
                end
            end
            repeat (DEV_HALF) @(negedge clk);
        end
        dev_data_low = ack_low;
        repeat (20) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (DEV_HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (20) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input logic par,
                             input logic ack_low, input logic inject);
        int inh, rts, n, d0, e0, exp_r;
        d0 = done_cnt;
        e0 = err_cnt;
        exp_res.push_back(ack_low ? 0 : 1);
        send_byte(b, par);
        if (inject) begin
            tx_data = PS2_CMD_RESET;
            tx_strb = 1'b1;
            @(negedge clk);
            tx_strb = 1'b0;
        end
        wait_release(inh, rts);
        if (!inject) begin
            checks++;
            if (inh != INH || rts != RTS) begin
                errors++;
                $display("FAIL %s rts_timing: inhibit=%0d rts=%0d, required %0d/%0d", tag, inh, rts, INH, RTS);
            end
        end
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b1) begin
            errors++;
            $display("FAIL %s release: clk_oe=%b data_oe=%b, required 0/1", tag, ps2_clk_oe, ps2_data_oe);
        end
        if (inject) begin
            tx_strb = 1'b1;
            @(negedge clk);
            tx_strb = 1'b0;
        end
        device_frame(ack_low, 11);
        n = 0;
        while (tx_busy === 1'b1 && n < 30000) begin
            n++;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        exp_r = exp_res.pop_front();
        checks++;
        if ((exp_r == 0 && (done_cnt - d0 != 1 || err_cnt - e0 != 0)) ||
            (exp_r == 1 && (done_cnt - d0 != 0 || err_cnt - e0 != 1))) begin
            errors++;
            $display("FAIL %s outcome: done=%0d error=%0d, required done=%0d error=%0d",
                     tag, done_cnt - d0, err_cnt - e0, exp_r == 0 ? 1 : 0, exp_r);
        end
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: clk_oe=%b data_oe=%b busy=%b, required 0/0/0",
                     tag, ps2_clk_oe, ps2_data_oe, tx_busy);
        end
        checks++;
        if (exp_bits.size() != 0) begin
            errors++;
            $display("FAIL %s leftover_bits: %0d remain, required 0", tag, exp_bits.size());
            exp_bits.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: %b, required 00000",
                     {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error} !== 5'b0) begin
            errors++;
            $display("FAIL idle_outputs: %b, required 00000",
                     {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error});
        end
    endtask

    task automatic test_send_ed();
        run_frame("send_ed", PS2_CMD_SET_LED, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_parity();
        run_frame("parity_00", 8'h00, 1'b1, 1'b1, 1'b0);
        run_frame("parity_f4", PS2_CMD_ENABLE, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_no_ack();
        run_frame("no_ack", 8'h5A, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        int inh, rts, n, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(PS2_CMD_ENABLE, 1'b0);
        wait_release(inh, rts);
        exp_bits.delete();
        n = 0;
        while (tx_error !== 1'b1 && n < int'(TMO) + 1000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != TMO) begin
            errors++;
            $display("FAIL timeout_latency: error after %0d cycles, required %0d", n, TMO);
        end
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_release: clk_oe=%b data_oe=%b busy=%b, required 0/0/0",
                     ps2_clk_oe, ps2_data_oe, tx_busy);
        end
        @(negedge clk);
        checks++;
        if (tx_error !== 1'b0 || err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
            errors++;
            $display("FAIL timeout_pulse: error=%b count=%0d done=%0d, required 0/1/0",
                     tx_error, err_cnt - e0, done_cnt - d0);
        end
    endtask

    task automatic test_busy_ignore();
        run_frame("busy_ignore", PS2_CMD_SET_LED, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        int inh, rts, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(PS2_CMD_SET_LED, 1'b1);
        wait_release(inh, rts);
        device_frame(1'b1, 5);
        rst     = 1'b1;
        tx_data = PS2_CMD_RESET;
        tx_strb = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        tx_strb = 1'b0;
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame: clk_oe=%b data_oe=%b busy=%b, required 0/0/0",
                     ps2_clk_oe, ps2_data_oe, tx_busy);
        end
        dev_clk_low = 1'b0;
        exp_bits.delete();
        repeat (100) @(negedge clk);
        checks++;
        if (done_cnt != d0 || err_cnt != e0 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_pulse: done=%0d error=%0d busy=%b, required 0/0/0",
                     done_cnt - d0, err_cnt - e0, tx_busy);
        end
        run_frame("after_reset", PS2_CMD_ENABLE, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        tx_data      = 8'h00;
        tx_strb      = 1'b0;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        test_reset();
        test_send_ed();
        test_parity();
        test_no_ack();
        test_timeout();
        test_busy_ignore();
        test_reset_mid_frame();
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
